// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline-stage buffer: circular buffer with synchronous flush and saturating stall counter.
// Optional zero-latency pass-through when empty is enabled by defining PIPE_STAGE_BYPASS_EN.
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      stall_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      stall_q, stall_d;
  logic             push;
  logic             pop;
  logic             stall;

  // Explicit wrap so non-power-of-two depths stay inside the array.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // s_ready looks only at registered occupancy, so there is no ready path through the stage.
  assign s_ready = (count_q < CNT_W'(DEPTH));
  assign stall   = s_valid && !s_ready;

`ifdef PIPE_STAGE_BYPASS_EN
  logic bypass;
  assign bypass  = (count_q == '0) && !flush;
  assign m_valid = bypass ? s_valid : (count_q != '0);
  assign m_data  = bypass ? s_data : mem_q[rp_q];
  // A word consumed on the bypass path never touches storage.
  assign push    = s_valid && s_ready && !(bypass && m_ready);
  assign pop     = (count_q != '0) && m_ready;
`else
  assign m_valid = (count_q != '0);
  assign m_data  = mem_q[rp_q];
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
`endif

  always_comb begin
    rp_d    = rp_q;
    wp_d    = wp_q;
    count_d = count_q;
    stall_d = stall_q;
    if (stall && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    if (flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wp_d = next_ptr(wp_q);
      end
      if (pop) begin
        rp_d = next_ptr(rp_q);
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Payload storage carries no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wp_q] <= s_data;
    end
  end

  assign count     = count_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf (DEPTH=3): reference model is a bounded FIFO queue.
module tb_pipe_stage_buf;

  localparam int W     = 16;
  localparam int DEPTH = 3;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             s_valid;
  logic             s_ready;
  logic [W-1:0]     s_data;
  logic             m_valid;
  logic             m_ready;
  logic [W-1:0]     m_data;
  logic [CNT_W-1:0] count;
  logic [31:0]      stall_cnt;

  pipe_stage_buf #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_stall = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_out = 0;
  bit           last_acc;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: samples at the falling edge, pops the scoreboard on each transfer.
  always @(negedge clk) begin
    if (!rst) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
      chk("s_ready", 32'(s_ready), 32'(exp_q.size() < DEPTH));
      chk("stall_cnt", stall_cnt, exp_stall);
      if (exp_q.size() != 0 && m_ready && !flush) begin
        chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        n_out++;
      end
    end
  end

  // One clock of stimulus; the model advances after the edge.
  task automatic cycle(input logic sv, input logic [W-1:0] sd, input logic mr, input logic fl);
    bit acc, stl;
    s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
    acc = sv && (exp_q.size() < DEPTH);
    stl = sv && !(exp_q.size() < DEPTH);
    @(posedge clk); #1;
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(sd);
    if (stl && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    last_acc = acc && !fl;
  endtask

  initial begin
    int base, t, i;
    logic         pend_v;
    logic [W-1:0] pend_d;
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_stall", stall_cnt, 0);
    rst = 1'b0;

    // Fill to full, then offer one more word for three cycles.
    cycle(1, 16'hA, 0, 0);
    cycle(1, 16'hB, 0, 0);
    cycle(1, 16'hC, 0, 0);
    repeat (3) cycle(1, 16'hD, 0, 0);
    chk("fill_count", 32'(count), 3);
    chk("fill_s_ready", 32'(s_ready), 0);
    chk("fill_stall", stall_cnt, 3);
    chk("fill_m_data", 32'(m_data), 32'hA);
    repeat (4) cycle(0, '0, 1, 0);

    // Streaming: one word per cycle, no stalls.
    base = n_out;
    for (int k = 0; k < 100; k++) cycle(1, W'(k), 1, 0);
    repeat (3) cycle(0, '0, 1, 0);
    chk("stream_out", 32'(n_out - base), 100);
    chk("stream_stall", stall_cnt, 3);

    // Wrap-around with m_ready toggling; data held until accepted.
    i = 0; t = 0;
    while (i < 10 && t < 100) begin
      cycle(1, W'(i), (t % 2) == 0, 0);
      if (last_acc) i++;
      t++;
    end
    chk("wrap_accepted", 32'(i), 10);
    repeat (6) cycle(0, '0, 1, 0);

    // Flush collision: the word offered with flush must never appear.
    cycle(1, 16'h11, 0, 0);
    cycle(1, 16'h22, 0, 0);
    cycle(1, 16'h55, 1, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_m_valid", 32'(m_valid), 0);
    repeat (3) cycle(0, '0, 1, 0);

    // Asynchronous reset between edges with three words held.
    cycle(1, 16'h31, 0, 0);
    cycle(1, 16'h32, 0, 0);
    cycle(1, 16'h33, 0, 0);
    chk("pre_rst_count", 32'(count), 3);
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_m_valid", 32'(m_valid), 0);
    chk("arst_stall", stall_cnt, 0);
    exp_q.delete();
    exp_stall = 0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    chk("arst_hold_count", 32'(count), 0);
    rst = 1'b0;
    cycle(1, 16'h77, 1, 0);
    chk("post_rst_m_data", 32'(m_data), 32'h77);

    // Randomised traffic honouring the hold-until-accepted rule.
    pend_v = 1'b0; pend_d = '0;
    for (int k = 0; k < 600; k++) begin
      logic mr, fl;
      if (!pend_v) begin
        pend_v = ($urandom_range(0, 3) != 0);
        pend_d = W'($urandom);
      end
      mr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 31) == 0);
      cycle(pend_v, pend_d, mr, fl);
      if (last_acc || fl) pend_v = 1'b0;
    end
    repeat (8) cycle(0, '0, 1, 0);
    chk("final_count", 32'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
